// File: rtl/mod_cnt_pkg.sv
// mod_cnt_pkg
//   Shared constants and helpers for the modulo-N down counter.
//   MOD_DEFAULT   : default count modulus (counts MOD-1 .. 0)
//   WIDTH_DEFAULT : default count width in bits
//   clamp()       : returns min(value, mod-1) so a load can never put the
//                   counter outside its legal range
package mod_cnt_pkg;

    localparam int MOD_DEFAULT   = 7;
    localparam int WIDTH_DEFAULT = 3;

    function automatic int unsigned clamp(input int unsigned value,
                                          input int unsigned mod);
        return (value < mod - 1) ? value : mod - 1;
    endfunction

endpackage

// File: rtl/mod_n_down_counter_tff.sv
// tff_sync
//   One bit of the down counter: a toggle flop with a parallel-load path.
//   Priority is reset, then load, then toggle.
//   clk : clock, rising edge
//   rst : synchronous active-high reset, clears q to 0
//   t   : toggle q on this edge
//   ld  : load d on this edge (overrides t)
//   d   : parallel-load data
//   q   : registered bit value
module tff_sync (
    input  logic clk,
    input  logic rst,
    input  logic t,
    input  logic ld,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk) begin
        if (rst)
            q <= 1'b0;
        else if (ld)
            q <= d;
        else if (t)
            q <= ~q;
    end

endmodule

// File: rtl/mod_n_down_counter.sv
// mod_n_down_counter
//   Modulo-MOD down counter: MOD-1, MOD-2, ..., 0, MOD-1, ... advancing on
//   enabled cycles. Built from one tff_sync per bit; the top only decodes
//   toggle/load enables, clamps the load value and produces tc and uf.
//
//   Build option: define MOD_DOWN_CNT_SAT_EN for saturating mode (count
//   stops at 0, uf pulses once after the 1 -> 0 step). Undefined: wrap mode.
//
//   Parameters: MOD (2..2**WIDTH), WIDTH
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset (count <= 0, uf <= 0)
//   en       : count enable
//   load     : parallel load strobe, beats en
//   load_val : value to load, clamped to MOD-1
//   count    : registered count
//   tc       : combinational terminal count (count == 0 && en), cascadable
//   uf       : registered underflow pulse
module mod_n_down_counter
    import mod_cnt_pkg::*;
#(
    parameter int MOD   = MOD_DEFAULT,
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             uf
);

    localparam logic [WIDTH-1:0] TOP_VAL = WIDTH'(MOD - 1);

    logic             at_zero;
    logic             dec;
    logic             wrap;
    logic             uf_set;
    logic             ld;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] ld_data;
    logic [WIDTH-1:0] lower_zero;   // bit i: all bits below i are 0
    logic [WIDTH-1:0] tgl;

    assign at_zero      = (count == '0);
    assign load_clamped = WIDTH'(clamp(32'(load_val), 32'(MOD)));

    // Plain decrement only from a non-zero count; reaching 0 is handled by
    // the wrap load (or by holding in saturating mode).
    assign dec = en & ~load & ~at_zero;

`ifdef MOD_DOWN_CNT_SAT_EN
    assign wrap   = 1'b0;
    assign uf_set = en & ~load & (count == WIDTH'(1));
`else
    assign wrap   = en & ~load & at_zero;
    assign uf_set = wrap;
`endif

    assign ld      = load | wrap;
    assign ld_data = load ? load_clamped : TOP_VAL;

    assign tc = at_zero & en;

    // Binary decrement: a bit flips when every lower bit is 0 (borrow ripple).
    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            if (i == 0) begin : g_lsb
                assign lower_zero[i] = 1'b1;
            end else begin : g_upper
                assign lower_zero[i] = lower_zero[i-1] & ~count[i-1];
            end

            assign tgl[i] = dec & lower_zero[i];

            tff_sync u_tff (
                .clk (clk),
                .rst (rst),
                .t   (tgl[i]),
                .ld  (ld),
                .d   (ld_data[i]),
                .q   (count[i])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst)
            uf <= 1'b0;
        else
            uf <= uf_set;
    end

endmodule

// File: tb/tb_mod_n_down_counter.sv
// tb_mod_n_down_counter
//   Self-checking bench: directed vector table for the documented sequences,
//   then randomized stimulus against a behavioural reference model.
module tb_mod_n_down_counter;

    localparam int MOD   = 7;
    localparam int WIDTH = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b0;
    logic             load = 1'b0;
    logic [WIDTH-1:0] load_val = '0;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             uf;

    int tests = 0;
    int failed = 0;

    // reference model state
    int m_count = 0;
    int m_uf = 0;

    mod_n_down_counter #(.MOD(MOD), .WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .tc       (tc),
        .uf       (uf)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit r;
        bit e;
        bit l;
        int lv;
        int exp_count;
        int exp_uf;
        int exp_tc;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive inputs mid-cycle, let one rising edge pass, sample 1 time unit later.
    task automatic apply(input bit r, input bit e, input bit l, input int lv);
        @(negedge clk);
        rst      = r;
        en       = e;
        load     = l;
        load_val = WIDTH'(lv);
        @(posedge clk);
        #1;
    endtask

    // Behavioural next-state from the counting rules.
    task automatic model_step(input bit r, input bit e, input bit l, input int lv);
        if (r) begin
            m_count = 0;
            m_uf = 0;
        end else if (l) begin
            m_count = (lv > MOD - 1) ? MOD - 1 : lv;
            m_uf = 0;
        end else if (e) begin
`ifdef MOD_DOWN_CNT_SAT_EN
            m_uf = (m_count == 1) ? 1 : 0;
            m_count = (m_count == 0) ? 0 : m_count - 1;
`else
            m_uf = (m_count == 0) ? 1 : 0;
            m_count = (m_count + MOD - 1) % MOD;
`endif
        end else begin
            m_uf = 0;
        end
    endtask

    vec_t vecs[$];

    initial begin
`ifndef MOD_DOWN_CNT_SAT_EN
        // reset, then wrap sequence 6..0,6
        vecs.push_back('{1, 0, 0, 0, 0, 0, 0});
        vecs.push_back('{0, 1, 0, 0, 6, 1, 0});
        vecs.push_back('{0, 1, 0, 0, 5, 0, 0});
        vecs.push_back('{0, 1, 0, 0, 4, 0, 0});
        vecs.push_back('{0, 1, 0, 0, 3, 0, 0});
        vecs.push_back('{0, 1, 0, 0, 2, 0, 0});
        vecs.push_back('{0, 1, 0, 0, 1, 0, 0});
        vecs.push_back('{0, 1, 0, 0, 0, 0, 1});
        vecs.push_back('{0, 1, 0, 0, 6, 1, 0});
        // load 3 with hold, then two decrements
        vecs.push_back('{0, 0, 1, 3, 3, 0, 0});
        vecs.push_back('{0, 1, 0, 0, 2, 0, 0});
        vecs.push_back('{0, 1, 0, 0, 1, 0, 0});
        // clamp: load 7 gives 6
        vecs.push_back('{0, 0, 1, 7, 6, 0, 0});
        // simultaneous load and enable: load wins
        vecs.push_back('{0, 0, 1, 4, 4, 0, 0});
        vecs.push_back('{0, 1, 1, 2, 2, 0, 0});
        // reset mid-count, then wrap on first enabled edge
        vecs.push_back('{0, 0, 1, 5, 5, 0, 0});
        vecs.push_back('{1, 1, 0, 0, 0, 0, 1});
        vecs.push_back('{0, 1, 0, 0, 6, 1, 0});
        // load of 0 raises no uf; hold keeps 0
        vecs.push_back('{0, 1, 1, 0, 0, 0, 1});
        vecs.push_back('{0, 0, 0, 0, 0, 0, 0});
        vecs.push_back('{0, 0, 0, 0, 0, 0, 0});
`else
        vecs.push_back('{1, 0, 0, 0, 0, 0, 0});
        vecs.push_back('{0, 0, 1, 2, 2, 0, 0});
        vecs.push_back('{0, 1, 0, 0, 1, 0, 0});
        vecs.push_back('{0, 1, 0, 0, 0, 1, 1});
        vecs.push_back('{0, 1, 0, 0, 0, 0, 1});
        vecs.push_back('{0, 1, 0, 0, 0, 0, 1});
        vecs.push_back('{0, 0, 1, 7, 6, 0, 0});
        vecs.push_back('{0, 1, 1, 0, 0, 0, 1});
        vecs.push_back('{0, 1, 0, 0, 0, 0, 1});
`endif

        foreach (vecs[k]) begin
            apply(vecs[k].r, vecs[k].e, vecs[k].l, vecs[k].lv);
            chk($sformatf("vec%0d count", k), int'(count), vecs[k].exp_count);
            chk($sformatf("vec%0d uf", k), int'(uf), vecs[k].exp_uf);
            chk($sformatf("vec%0d tc", k), int'(tc), vecs[k].exp_tc);
        end

        // Randomized run against the model; start from a known reset.
        apply(1, 0, 0, 0);
        model_step(1, 0, 0, 0);
        for (int n = 0; n < 3000; n++) begin
            bit r, e, l;
            int lv;
            r  = ($urandom_range(0, 49) == 0);
            l  = ($urandom_range(0, 7) == 0);
            e  = ($urandom_range(0, 9) < 7);
            lv = $urandom_range(0, (1 << WIDTH) - 1);
            apply(r, e, l, lv);
            model_step(r, e, l, lv);
            chk($sformatf("rnd%0d count", n), int'(count), m_count);
            chk($sformatf("rnd%0d uf", n), int'(uf), m_uf);
            chk($sformatf("rnd%0d tc", n), int'(tc), (m_count == 0 && e) ? 1 : 0);
            chk($sformatf("rnd%0d range", n), (int'(count) < MOD) ? 1 : 0, 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
